// File: rtl/capture_seq.sv
// capture_seq: sequences one ADC burst into the capture SRAM, then reads it out as framed packets.
// Optional macro CAPTURE_SEQ_SELF_TEST_EN adds a ramp test-pattern source during capture.
`timescale 1ns/1ps
module capture_seq #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              pktctrl_clk,
  input  logic              pktctrl_rstn,
  input  logic              rf_capture_start,
  input  logic              rf_capture_mode,
  input  logic              rf_capture_again,
  input  logic              rf_96path_en,
  input  logic [1:0]        rf_pkt_data_length,
  input  logic [15:0]       rf_pkt_idle_length,
`ifdef CAPTURE_SEQ_SELF_TEST_EN
  input  logic              rf_self_test_mode,
  output logic [17:0]       test_wr_data,
`endif
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              pkt_valid,
  output logic              pkt_sof,
  output logic              pkt_eof,
  output logic              capture_busy,
  output logic              capture_done
);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_READ, S_GAP, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_FULL = ADDR_W'(DEPTH - 32'd1);
  localparam logic [ADDR_W-1:0] LAST_HALF = ADDR_W'(DEPTH / 32'd2 - 32'd1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  function automatic logic [10:0] pkt_last_f(input logic [1:0] len);
    case (len)
      2'd0:    pkt_last_f = 11'd255;
      2'd1:    pkt_last_f = 11'd511;
      2'd2:    pkt_last_f = 11'd1023;
      default: pkt_last_f = 11'd2047;
    endcase
  endfunction

  state_t             r_state, w_state_nxt;
  logic               r_start_d, r_again_d, r_edge_ok, r_start_rise;
  logic [ADDR_W-1:0]  r_cap_last, w_cap_last_nxt;
  logic [10:0]        r_pkt_last, w_pkt_last_nxt;
  logic [ADDR_W-1:0]  r_wr_addr, w_wr_addr_nxt;
  logic [ADDR_W-1:0]  r_rd_addr, w_rd_addr_nxt;
  logic [10:0]        r_wcnt, w_wcnt_nxt;
  logic [15:0]        r_idle_cnt, w_idle_nxt;
  logic               r_wr_en, r_rd_en, r_pkt_valid, r_pkt_sof, r_pkt_eof, r_busy, r_done;
  logic               w_again_rise, w_rd_last, w_pkt_end;

  // r_edge_ok masks the first cycle after reset so a level already high is not taken as an edge.
  assign w_again_rise = rf_capture_again & ~r_again_d & r_edge_ok;
  assign w_rd_last    = (r_rd_addr == r_cap_last);
  assign w_pkt_end    = (r_wcnt == r_pkt_last) | w_rd_last;

  // Edge-detect registers for the start and replay controls.
  always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
    if (!pktctrl_rstn) begin
      r_start_d    <= 1'b0;
      r_again_d    <= 1'b0;
      r_edge_ok    <= 1'b0;
      r_start_rise <= 1'b0;
    end else begin
      r_start_d    <= rf_capture_start;
      r_again_d    <= rf_capture_again;
      r_edge_ok    <= 1'b1;
      r_start_rise <= rf_capture_start & ~r_start_d & r_edge_ok;
    end
  end

  // State and counter registers.
  always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
    if (!pktctrl_rstn) begin
      r_state    <= S_IDLE;
      r_cap_last <= ADDR_ZERO;
      r_pkt_last <= 11'd0;
      r_wr_addr  <= ADDR_ZERO;
      r_rd_addr  <= ADDR_ZERO;
      r_wcnt     <= 11'd0;
      r_idle_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cap_last <= w_cap_last_nxt;
      r_pkt_last <= w_pkt_last_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_idle_cnt <= w_idle_nxt;
    end
  end

  // Next-state and counter logic; a low start level overrides every transition.
  always_comb begin
    w_state_nxt    = r_state;
    w_cap_last_nxt = r_cap_last;
    w_pkt_last_nxt = r_pkt_last;
    w_wr_addr_nxt  = r_wr_addr;
    w_rd_addr_nxt  = r_rd_addr;
    w_wcnt_nxt     = r_wcnt;
    w_idle_nxt     = r_idle_cnt;
    if (!rf_capture_start) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_start_rise) begin
            w_state_nxt    = S_CAPTURE;
            w_wr_addr_nxt  = ADDR_ZERO;
            w_cap_last_nxt = rf_96path_en ? LAST_FULL : LAST_HALF;
            w_pkt_last_nxt = pkt_last_f(rf_pkt_data_length);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (r_wr_addr == r_cap_last) begin
            w_state_nxt   = S_READ;
            w_rd_addr_nxt = ADDR_ZERO;
            w_wcnt_nxt    = 11'd0;
          end else begin
            w_wr_addr_nxt = r_wr_addr + ADDR_ONE;
          end
        end
        S_READ: begin
          if (w_pkt_end && w_rd_last) begin
            w_state_nxt = S_DONE;
          end else if (w_pkt_end) begin
            w_rd_addr_nxt = r_rd_addr + ADDR_ONE;
            w_wcnt_nxt    = 11'd0;
            w_idle_nxt    = rf_pkt_idle_length;
            w_state_nxt   = (rf_pkt_idle_length == 16'd0) ? S_READ : S_GAP;
          end else begin
            w_rd_addr_nxt = r_rd_addr + ADDR_ONE;
            w_wcnt_nxt    = r_wcnt + 11'd1;
          end
        end
        S_GAP: begin
          if (r_idle_cnt <= 16'd1) begin
            w_state_nxt = S_READ;
            w_idle_nxt  = 16'd0;
          end else begin
            w_idle_nxt = r_idle_cnt - 16'd1;
          end
        end
        S_DONE: begin
          if (rf_capture_mode) begin
            w_state_nxt    = S_CAPTURE;
            w_wr_addr_nxt  = ADDR_ZERO;
            w_cap_last_nxt = rf_96path_en ? LAST_FULL : LAST_HALF;
            w_pkt_last_nxt = pkt_last_f(rf_pkt_data_length);
          end else if (w_again_rise) begin
            w_state_nxt   = S_READ;
            w_rd_addr_nxt = ADDR_ZERO;
            w_wcnt_nxt    = 11'd0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered strobes; packet framing trails the read strobe by one cycle to match SRAM latency.
  always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
    if (!pktctrl_rstn) begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_pkt_sof   <= 1'b0;
      r_pkt_eof   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wr_en     <= (w_state_nxt == S_CAPTURE);
      r_rd_en     <= (w_state_nxt == S_READ);
      r_pkt_valid <= r_rd_en;
      r_pkt_sof   <= r_rd_en & (r_wcnt == 11'd0);
      r_pkt_eof   <= r_rd_en & w_pkt_end;
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

`ifdef CAPTURE_SEQ_SELF_TEST_EN
  logic [17:0] r_test_wr_data;

  // Ramp pattern aligned with the write strobe and address.
  always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
    if (!pktctrl_rstn) begin
      r_test_wr_data <= 18'd0;
    end else if ((w_state_nxt == S_CAPTURE) && rf_self_test_mode) begin
      r_test_wr_data <= {3'b000, 15'(w_wr_addr_nxt)};
    end else begin
      r_test_wr_data <= 18'd0;
    end
  end

  assign test_wr_data = r_test_wr_data;
`endif

  assign mem_wr_en    = r_wr_en;
  assign mem_wr_addr  = r_wr_addr;
  assign mem_rd_en    = r_rd_en;
  assign mem_rd_addr  = r_rd_addr;
  assign pkt_valid    = r_pkt_valid;
  assign pkt_sof      = r_pkt_sof;
  assign pkt_eof      = r_pkt_eof;
  assign capture_busy = r_busy;
  assign capture_done = r_done;

endmodule

// File: tb/tb_capture_seq.sv
// Self-checking bench for capture_seq: table of full capture/readout scenarios plus directed corner sequences.
`timescale 1ns/1ps
module tb_capture_seq;

  localparam int AW = 15;

  logic          clk, rstn;
  logic          start, mode, again, path;
  logic [1:0]    len;
  logic [15:0]   idle;
  logic          wr_en, rd_en, pv, sof, eof, busy, done;
  logic [AW-1:0] wr_addr, rd_addr;

  logic          b_start;
  logic          b_wr_en, b_rd_en, b_pv, b_sof, b_eof, b_busy, b_done;
  logic [AW-1:0] b_wr_addr, b_rd_addr;

  int n_checks = 0;
  int n_err    = 0;

  capture_seq #(.ADDR_W(AW), .DEPTH(4096)) u_a (
    .pktctrl_clk(clk), .pktctrl_rstn(rstn),
    .rf_capture_start(start), .rf_capture_mode(mode), .rf_capture_again(again),
    .rf_96path_en(path), .rf_pkt_data_length(len), .rf_pkt_idle_length(idle),
    .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_rd_en(rd_en), .mem_rd_addr(rd_addr),
    .pkt_valid(pv), .pkt_sof(sof), .pkt_eof(eof),
    .capture_busy(busy), .capture_done(done)
  );

  capture_seq #(.ADDR_W(AW), .DEPTH(3000)) u_b (
    .pktctrl_clk(clk), .pktctrl_rstn(rstn),
    .rf_capture_start(b_start), .rf_capture_mode(1'b0), .rf_capture_again(1'b0),
    .rf_96path_en(1'b1), .rf_pkt_data_length(2'd3), .rf_pkt_idle_length(16'd2),
    .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr), .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr),
    .pkt_valid(b_pv), .pkt_sof(b_sof), .pkt_eof(b_eof),
    .capture_busy(b_busy), .capture_done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        path;
    logic [1:0]  len;
    logic [15:0] idle;
    int          cap;
    int          pkt_words;
    int          n_pkts;
    int          last_words;
  } vec_t;

  vec_t tbl[4];

  // Monitor results of run_until_done
  int n_wr, n_rd, n_valid, n_pkt, first_len, last_len, cur_len, gap_cnt;
  int wr_addr_err, rd_addr_err, rd_follow_err, wr_after_rd, align_err, framing_err, gap_err, busy_err;

  task automatic run_until_done(input int cap, input int pw, input int gap_exp, input int budget);
    logic prev_wr, prev_rd, exp_eof;
    n_wr = 0; n_rd = 0; n_valid = 0; n_pkt = 0; first_len = 0; last_len = 0; cur_len = 0; gap_cnt = 0;
    wr_addr_err = 0; rd_addr_err = 0; rd_follow_err = 0; wr_after_rd = 0;
    align_err = 0; framing_err = 0; gap_err = 0; busy_err = 0;
    prev_wr = 1'b0; prev_rd = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (wr_en) begin
        if (int'(wr_addr) != n_wr) wr_addr_err++;
        if (n_rd > 0) wr_after_rd++;
        n_wr++;
      end
      if (rd_en) begin
        if (n_rd == 0 && n_wr > 0 && !prev_wr) rd_follow_err++;
        if (int'(rd_addr) != n_rd) rd_addr_err++;
        n_rd++;
      end
      if (pv != prev_rd) align_err++;
      if (pv) begin
        if (sof != (cur_len == 0)) framing_err++;
        if (sof && n_pkt > 0 && gap_cnt != gap_exp) gap_err++;
        cur_len++;
        n_valid++;
        exp_eof = (cur_len == pw) || (n_valid == cap);
        if (eof != exp_eof) framing_err++;
        if (eof) begin
          n_pkt++;
          if (n_pkt == 1) first_len = cur_len;
          last_len = cur_len;
          cur_len = 0;
          gap_cnt = 0;
        end
      end else if (n_pkt > 0) begin
        gap_cnt++;
      end
      if (!done && !busy) busy_err++;
      prev_wr = wr_en;
      prev_rd = rd_en;
      if (done) break;
      tick();
    end
  endtask

  initial begin
    int cnt;
    int eof_addr;
    logic [AW-1:0] b_prev_addr;

    tbl[0] = '{1'b1, 2'd0, 16'd10, 4096, 256,  16, 256};
    tbl[1] = '{1'b0, 2'd0, 16'd0,  2048, 256,  8,  256};
    tbl[2] = '{1'b1, 2'd3, 16'd1,  4096, 2048, 2,  2048};
    tbl[3] = '{1'b0, 2'd2, 16'd3,  2048, 1024, 2,  1024};

    rstn = 1'b0; start = 1'b0; mode = 1'b0; again = 1'b0; path = 1'b0;
    len = 2'd0; idle = 16'd0; b_start = 1'b0;
    #2;
    chk("reset_strobes", {wr_en, rd_en, pv, sof, eof, busy, done}, 0);
    chk("reset_addrs", int'(wr_addr) + int'(rd_addr), 0);
    #20 rstn = 1'b1;
    tick(); tick();

    // Reset mid-capture with start held high
    start = 1'b1;
    tick();
    chk("lat_cycle1_wr_en", wr_en, 0);
    tick();
    chk("lat_cycle2_wr_en", wr_en, 1);
    repeat (50) tick();
    chk("midcap_wr_en", wr_en, 1);
    #1 rstn = 1'b0;
    #1;
    chk("async_reset_outs", {wr_en, rd_en, pv, busy, done}, 0);
    chk("async_reset_wr_addr", int'(wr_addr), 0);
    #2 rstn = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      if (wr_en || busy) cnt++;
    end
    chk("no_restart_held_start", cnt, 0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("retoggle_cycle1", wr_en, 0);
    tick();
    chk("retoggle_cycle2_wr", {wr_en, busy}, 3);
    start = 1'b0; tick();
    chk("abort_capture", {wr_en, busy}, 0);

    // Table of full capture + readout scenarios
    for (int v = 0; v < 4; v++) begin
      start = 1'b0; tick(); tick();
      path = tbl[v].path; len = tbl[v].len; idle = tbl[v].idle;
      start = 1'b1;
      tick();
      chk("scn_lat1", wr_en, 0);
      tick();
      chk("scn_lat2", wr_en, 1);
      run_until_done(tbl[v].cap, tbl[v].pkt_words, int'(tbl[v].idle), 20000);
      chk("scn_done", done, 1);
      chk("scn_writes", n_wr, tbl[v].cap);
      chk("scn_wr_addr_err", wr_addr_err, 0);
      chk("scn_reads", n_rd, tbl[v].cap);
      chk("scn_rd_addr_err", rd_addr_err, 0);
      chk("scn_rd_follows_wr", rd_follow_err, 0);
      chk("scn_wr_during_read", wr_after_rd, 0);
      chk("scn_valid_align", align_err, 0);
      chk("scn_valid_words", n_valid, tbl[v].cap);
      chk("scn_packets", n_pkt, tbl[v].n_pkts);
      chk("scn_first_len", first_len, tbl[v].pkt_words);
      chk("scn_last_len", last_len, tbl[v].last_words);
      chk("scn_framing", framing_err, 0);
      chk("scn_gap", gap_err, 0);
      chk("scn_busy", busy_err, 0);
      tick();
      chk("scn_done_hold", {done, busy, wr_en, rd_en}, 8);
    end

    // Replay from DONE (last table entry: 2048 words, 1024-word packets, idle 3)
    again = 1'b1;
    tick();
    chk("replay_first_rd", {rd_en, wr_en, done, busy}, 9);
    chk("replay_rd_addr", int'(rd_addr), 0);
    again = 1'b0;
    run_until_done(2048, 1024, 3, 20000);
    chk("replay_done", done, 1);
    chk("replay_no_writes", n_wr, 0);
    chk("replay_reads", n_rd, 2048);
    chk("replay_rd_addr_err", rd_addr_err, 0);
    chk("replay_packets", n_pkt, 2);
    chk("replay_framing", framing_err, 0);

    // Again edge and start low in the same cycle: abort wins
    start = 1'b0; again = 1'b1;
    tick();
    chk("again_vs_abort", {done, busy, rd_en}, 0);
    tick();
    chk("again_vs_abort_hold", {done, busy, rd_en}, 0);
    again = 1'b0;

    // Abort during READ at packet word 100
    path = 1'b0; len = 2'd0; idle = 16'd0; mode = 1'b0;
    tick();
    start = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (rd_en && int'(rd_addr) == 100) begin
        cnt = 1;
        break;
      end
    end
    chk("abort_word100_reached", cnt, 1);
    start = 1'b0;
    tick();
    chk("abort_rd_busy", {rd_en, busy}, 0);
    chk("abort_trailing_valid", {pv, eof}, 2);
    tick();
    chk("abort_valid_gone", pv, 0);

    // Continuous mode: re-capture one cycle after DONE
    mode = 1'b1; path = 1'b0; len = 2'd3; idle = 16'd0;
    tick();
    start = 1'b1;
    tick(); tick();
    run_until_done(2048, 2048, 0, 20000);
    chk("cont_done", done, 1);
    chk("cont_packets", n_pkt, 1);
    tick();
    chk("cont_recapture", {wr_en, done, busy}, 5);
    chk("cont_recapture_addr", int'(wr_addr), 0);
    start = 1'b0; mode = 1'b0;
    tick();
    chk("cont_abort", {wr_en, busy}, 0);

    // Non-power-of-two depth: 3000 words, 2048-word packets, last truncated to 952
    b_start = 1'b1;
    tick(); tick();
    n_wr = 0; n_pkt = 0; first_len = 0; last_len = 0; cur_len = 0; eof_addr = -1;
    b_prev_addr = '0;
    for (int c = 0; c < 10000; c++) begin
      if (b_wr_en) n_wr++;
      if (b_pv) begin
        cur_len++;
        if (b_eof) begin
          n_pkt++;
          if (n_pkt == 1) first_len = cur_len;
          last_len = cur_len;
          cur_len = 0;
          eof_addr = int'(b_prev_addr);
        end
      end
      b_prev_addr = b_rd_addr;
      if (b_done) break;
      tick();
    end
    chk("trunc_done", b_done, 1);
    chk("trunc_writes", n_wr, 3000);
    chk("trunc_packets", n_pkt, 2);
    chk("trunc_first_len", first_len, 2048);
    chk("trunc_last_len", last_len, 952);
    chk("trunc_eof_addr", eof_addr, 2999);
    b_start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
